moonbase_io_periph: RTL and testbench
=====================================

Name: moonbase_io_periph

Overview:
- Memory-mapped I/O peripheral on the 4-bit CPU's external bus, downstream of the CPU.
- Consumes the CPU's 8-bit multiplexed address/data output and contains its own copy of the external 7-bit address latch.
- Provides an 8-bit GPIO output port, a synchronised 8-bit GPIO input port and an 8-bit down-counting timer.
- Returns 2-bit read data on the CPU's device-read lines (CPU io_in[7:6]).

Parameters:
- BASE_ADDR, 7'h78: device window base. Bits [2:0] must be 0; the window is BASE_ADDR..BASE_ADDR+7.
- PRESCALE, 16: timer tick divider used when prescale is enabled. Must be ≥2.

Ports:
- clk  in  1  system clock, same clock as the CPU.
- reset_n  in  1  asynchronous, active-low reset.
- bus_in  in  8  CPU bus output. Bit [7] is the address strobe. With strobe=1, [6:0] is the address. With strobe=0, [4] is write_data_n and [3:0] is write data.
- data_out  out  2  read data to the CPU device-read lines.
- data_oe  out  1  high when the latched address is inside the window; gates the shared device-read lines.
- gpio_in  in  8  asynchronous external inputs.
- gpio_out  out  8  registered output port.
- timer_expired  out  1  sticky expiry flag.

Behaviour:
- Reset (asynchronous, reset_n=0): addr_q=0, addr_valid=0, gpio_out=0, reload=0, count=0, running=0, autoreload=0, prescale_en=0, expired=0, prescaler=0, synchroniser flops=0. data_oe=0 and data_out=0 while addr_valid=0.
- Address latch: at any posedge with bus_in[7]=1, addr_q<=bus_in[6:0] and addr_valid<=1.
- Window hit: hit = addr_valid && addr_q[6:3]==BASE_ADDR[6:3]. data_oe=hit, combinational from registers.
- Write: occurs at a posedge with bus_in[7]=0, bus_in[4]=0 and hit. Data is bus_in[3:0] to offset addr_q[2:0]; single cycle, no handshake.
  - 0: gpio_out[3:0]
  - 1: gpio_out[7:4]
  - 2: reload[3:0]
  - 3: reload[7:4]
  - 4: control. d[0]=1 starts (count<=reload, running<=1, prescaler<=0); d[0]=0 stops (running<=0, prescaler<=0). d[1] sets autoreload. d[2]=1 clears expired. d[3] sets prescale_en.
  - 5-7: ignored.
- Writes outside the window, or with bus_in[4]=1, have no effect.
- Read: data_out is combinational from addr_q[2:0]; it is 0 when !hit.
  - 0: gin[1:0]
  - 1: gin[3:2]
  - 2: gin[5:4]
  - 3: gin[7:6]
  - 4: {running, expired}
  - 5: {prescale_en, autoreload}
  - 6, 7: 2'b00
- Read timing: the address is latched at the CPU's phase-4 edge, and data_out is valid throughout phase 5, so there is zero additional latency.
- GPIO input: gin is gpio_in passed through a 2-flop synchroniser. A change on gpio_in is visible on data_out 2 clocks later.
- Timer tick:
  - prescale_en=0: tick every clock while running.
  - prescale_en=1: prescaler counts 0..PRESCALE-1 while running; tick when it wraps to 0.
- On tick with running=1:
  - count!=0: count<=count-1.
  - count==0: expired<=1. If autoreload, count<=reload and running stays 1; else running<=0.
- Start with reload=0 expires on the first tick.
- Period with autoreload: (reload+1) ticks.
- Simultaneous events:
  - Expiry and a clear write (d[2]=1) in the same cycle: set wins, expired=1.
  - Start write and tick in the same cycle: start wins (count<=reload, no decrement).
  - Stop write and tick in the same cycle: stop wins, no expiry.
- A start write while running restarts from reload.
- Writes to reload while running do not affect count until the next start or autoreload.
- timer_expired = expired.
- Mid-operation reset clears all state immediately and asynchronously; there is no partial write.

Test Plan:
- Reset: pulse reset_n low mid-count → all outputs 0, data_oe=0. Then drive strobe with 7'h7C → data_oe=1, data_out=2'b00.
- GPIO: latch 7'h78, write 4'hA; latch 7'h79, write 4'h5 → gpio_out=8'h5A. Latch 7'h10, write 4'hF → gpio_out unchanged, data_oe=0.
- GPIO input: gpio_in=8'hC6, latch 7'h7B → data_out=2'b11 (gin[7:6]) from the 2nd clock after the change; latch 7'h78 → 2'b10.
- One-shot: reload=8'h03, prescale off, write control 4'b0001 → expired rises exactly 4 clocks after the write edge and running drops. Offset-4 read → 2'b01.
- Autoreload with prescale: PRESCALE=16, reload=1, control 4'b1011 → expired set after 32 clocks and running stays 1. Write control 4'b0101 in the cycle that coincides with the next expiry → expired remains 1.
- Write-enable qualification: strobe=0 with bus_in[4]=1 on an in-window address → no register change.

Source files
------------

// File: rtl/moonbase_io_periph.sv
// Memory-mapped GPIO/timer peripheral on the 4-bit CPU's multiplexed external bus.
// Keeps its own copy of the address latch and answers reads on the 2-bit device-read lines.
module moonbase_io_periph #(
   parameter logic [6:0] BASE_ADDR = 7'h78,
   parameter int         PRESCALE  = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] bus_in,
   output logic [1:0] data_out,
   output logic       data_oe,
   input  logic [7:0] gpio_in,
   output logic [7:0] gpio_out,
   output logic       timer_expired
);

   localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

   logic [6:0]    addr_q, addr_d;
   logic          avld_q, avld_d;
   logic [7:0]    gout_q, gout_d;
   logic [7:0]    reload_q, reload_d;
   logic [7:0]    count_q, count_d;
   logic          running_q, running_d;
   logic          autorl_q, autorl_d;
   logic          pre_en_q, pre_en_d;
   logic          expired_q, expired_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [7:0]    sync1_q, gin_q;

   logic hit, wr, ctrl_wr, tick, expire;
   logic unused_bus5;

   assign unused_bus5   = bus_in[5];
   assign hit           = avld_q && (addr_q[6:3] == BASE_ADDR[6:3]);
   assign wr            = !bus_in[7] && !bus_in[4] && hit;
   assign ctrl_wr       = wr && (addr_q[2:0] == 3'd4);
   assign tick          = running_q && (!pre_en_q || presc_q == PW'(PRESCALE - 1));
   assign data_oe       = hit;
   assign gpio_out      = gout_q;
   assign timer_expired = expired_q;

   always_comb begin
      data_out = 2'b00;
      if (hit) begin
         case (addr_q[2:0])
            3'd0:    data_out = gin_q[1:0];
            3'd1:    data_out = gin_q[3:2];
            3'd2:    data_out = gin_q[5:4];
            3'd3:    data_out = gin_q[7:6];
            3'd4:    data_out = {running_q, expired_q};
            3'd5:    data_out = {pre_en_q, autorl_q};
            default: data_out = 2'b00;
         endcase
      end
   end

   always_comb begin
      addr_d    = addr_q;
      avld_d    = avld_q;
      gout_d    = gout_q;
      reload_d  = reload_q;
      count_d   = count_q;
      running_d = running_q;
      autorl_d  = autorl_q;
      pre_en_d  = pre_en_q;
      expired_d = expired_q;
      presc_d   = presc_q;
      expire    = 1'b0;

      if (bus_in[7]) begin
         addr_d = bus_in[6:0];
         avld_d = 1'b1;
      end

      if (running_q && pre_en_q)
         presc_d = (presc_q == PW'(PRESCALE - 1)) ? '0 : presc_q + 1'b1;

      if (tick) begin
         if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
         end else begin
            expire = 1'b1;
            if (autorl_q) count_d   = reload_q;
            else          running_d = 1'b0;
         end
      end

      // A control write overrides the tick's effect on count/running; only a stop also
      // suppresses the expiry flag, so start+expiry still leaves expired set.
      if (ctrl_wr) begin
         running_d = bus_in[0];
         count_d   = bus_in[0] ? reload_q : count_q;
         presc_d   = '0;
         autorl_d  = bus_in[1];
         pre_en_d  = bus_in[3];
         if (!bus_in[0]) expire = 1'b0;
      end

      if (expire)                     expired_d = 1'b1;
      else if (ctrl_wr && bus_in[2])  expired_d = 1'b0;

      if (wr) begin
         case (addr_q[2:0])
            3'd0:    gout_d[3:0]   = bus_in[3:0];
            3'd1:    gout_d[7:4]   = bus_in[3:0];
            3'd2:    reload_d[3:0] = bus_in[3:0];
            3'd3:    reload_d[7:4] = bus_in[3:0];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         addr_q    <= '0;
         avld_q    <= 1'b0;
         gout_q    <= '0;
         reload_q  <= '0;
         count_q   <= '0;
         running_q <= 1'b0;
         autorl_q  <= 1'b0;
         pre_en_q  <= 1'b0;
         expired_q <= 1'b0;
         presc_q   <= '0;
         sync1_q   <= '0;
         gin_q     <= '0;
      end else begin
         addr_q    <= addr_d;
         avld_q    <= avld_d;
         gout_q    <= gout_d;
         reload_q  <= reload_d;
         count_q   <= count_d;
         running_q <= running_d;
         autorl_q  <= autorl_d;
         pre_en_q  <= pre_en_d;
         expired_q <= expired_d;
         presc_q   <= presc_d;
         sync1_q   <= gpio_in;
         gin_q     <= sync1_q;
      end
   end

endmodule

// File: tb/tb_moonbase_io_periph.sv
// Random + directed bus traffic against a clock-level behavioural model of the peripheral.
// Expected observations are queued at stimulus time and popped by an independent monitor.
module tb_moonbase_io_periph;

   localparam logic [6:0] BASE  = 7'h78;
   localparam int         PRESC = 16;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [7:0] bus_in = 8'h00;
   logic [7:0] gpio_in = 8'h00;
   logic [1:0] data_out;
   logic       data_oe;
   logic [7:0] gpio_out;
   logic       timer_expired;

   moonbase_io_periph #(.BASE_ADDR(BASE), .PRESCALE(PRESC)) dut (
      .clk(clk), .reset_n(reset_n), .bus_in(bus_in), .data_out(data_out),
      .data_oe(data_oe), .gpio_in(gpio_in), .gpio_out(gpio_out),
      .timer_expired(timer_expired)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       oe;
      logic [1:0] dout;
      logic [7:0] gout;
      logic       exp;
   } obs_t;

   obs_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   logic [7:0] gpio_v = 8'h00;

   // reference state
   int  m_addr, m_gout, m_rel, m_cnt, m_pc, m_s1, m_gin;
   bit  m_av, m_run, m_auto, m_pen, m_exp;

   function automatic bit m_hit();
      return m_av && (m_addr / 8 == int'(BASE) / 8);
   endfunction

   function automatic obs_t m_obs();
      obs_t o;
      int   off, v;
      off = m_addr % 8;
      v = 0;
      if (off < 4)       v = (m_gin >> (2 * off)) % 4;
      else if (off == 4) v = 2 * int'(m_run) + int'(m_exp);
      else if (off == 5) v = 2 * int'(m_pen) + int'(m_auto);
      o.oe   = m_hit();
      o.dout = m_hit() ? 2'(v) : 2'b00;
      o.gout = 8'(m_gout);
      o.exp  = m_exp;
      return o;
   endfunction

   function automatic void m_reset();
      m_addr = 0; m_av = 0; m_gout = 0; m_rel = 0; m_cnt = 0; m_pc = 0;
      m_s1 = 0; m_gin = 0; m_run = 0; m_auto = 0; m_pen = 0; m_exp = 0;
   endfunction

   // One clock edge of the peripheral, from the bus byte presented before it.
   function automatic void m_step(input logic [7:0] b);
      bit strobe, wr, ticked, fired;
      int off, d, pc_next;
      strobe = b[7];
      d      = int'(b[3:0]);
      off    = m_addr % 8;
      wr     = !strobe && !b[4] && m_hit();
      ticked = 0;
      fired  = 0;
      pc_next = m_pc;
      if (m_run) begin
         if (m_pen) begin
            pc_next = (m_pc + 1) % PRESC;
            ticked  = (pc_next == 0);
         end else begin
            ticked = 1;
         end
      end
      if (wr && off == 4) begin
         if (ticked && m_cnt == 0 && d % 2 == 1) fired = 1;
         if (d % 2 == 1) m_cnt = m_rel;
         m_run  = (d % 2 == 1);
         m_pc   = 0;
         m_auto = ((d / 2) % 2 == 1);
         m_pen  = ((d / 8) % 2 == 1);
         if (fired)                m_exp = 1;
         else if ((d / 4) % 2 == 1) m_exp = 0;
      end else begin
         m_pc = pc_next;
         if (ticked) begin
            if (m_cnt > 0) m_cnt = m_cnt - 1;
            else begin
               m_exp = 1;
               if (m_auto) m_cnt = m_rel;
               else        m_run = 0;
            end
         end
      end
      if (wr) begin
         case (off)
            0: m_gout = (m_gout / 16) * 16 + d;
            1: m_gout = d * 16 + m_gout % 16;
            2: m_rel  = (m_rel / 16) * 16 + d;
            3: m_rel  = d * 16 + m_rel % 16;
            default: ;
         endcase
      end
      if (strobe) begin
         m_addr = int'(b[6:0]);
         m_av   = 1;
      end
      m_gin = m_s1;
      m_s1  = int'(gpio_in);
   endfunction

   task automatic chk(input obs_t e, input string tag);
      obs_t a;
      a = {data_oe, data_out, gpio_out, timer_expired};
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s @%0t: got oe=%b dout=%b gpio=%h exp=%b, want oe=%b dout=%b gpio=%h exp=%b",
                  tag, $time, a.oe, a.dout, a.gout, a.exp, e.oe, e.dout, e.gout, e.exp);
      end
   endtask

   task automatic cyc(input logic [7:0] b);
      @(negedge clk);
      reset_n = 1'b1;
      bus_in  = b;
      gpio_in = gpio_v;
      m_step(b);
      sb.push_back(m_obs());
   endtask

   task automatic strobe(input logic [6:0] a);
      cyc({1'b1, a});
   endtask

   task automatic wdat(input logic [3:0] d);
      cyc({4'b0000, d});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(8'h10);
   endtask

   task automatic rst();
      @(negedge clk);
      reset_n = 1'b0;
      bus_in  = 8'h00;
      m_reset();
      #1 chk(m_obs(), "async_reset");
      sb.push_back(m_obs());
   endtask

   initial begin : monitor
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) chk(sb.pop_front(), "scoreboard");
      end
   end

   initial begin : stim
      logic [6:0] a;
      int r;
      m_reset();
      rst();

      // reset mid-count, then read control offset
      strobe(7'h7A); wdat(4'h8); strobe(7'h7C); wdat(4'h1);
      idle(3);
      rst();
      strobe(7'h7C);
      idle(1);

      // GPIO out, out-of-window write
      strobe(7'h78); wdat(4'hA); strobe(7'h79); wdat(4'h5);
      strobe(7'h10); wdat(4'hF);

      // GPIO input synchroniser
      gpio_v = 8'hC6;
      strobe(7'h7B); idle(3); strobe(7'h78); idle(1);

      // one-shot, reload 3
      strobe(7'h7A); wdat(4'h3); strobe(7'h7B); wdat(4'h0);
      strobe(7'h7C); wdat(4'h1); idle(6);

      // autoreload + prescale, then start+clear exactly on the second expiry
      strobe(7'h7A); wdat(4'h1); strobe(7'h7B); wdat(4'h0);
      strobe(7'h7C); wdat(4'hB); idle(63); wdat(4'h5); idle(4);
      wdat(4'h4); wdat(4'h0); idle(2);

      // write with write_data_n high on an in-window address
      strobe(7'h78); cyc(8'h13); strobe(7'h7A); cyc(8'h1F); strobe(7'h7C); cyc(8'h1F);
      idle(2);

      // randomized traffic
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 9) == 0) gpio_v = 8'($urandom);
         if ($urandom_range(0, 299) == 0) rst();
         r = int'($urandom_range(0, 9));
         if (r <= 2) begin
            if ($urandom_range(0, 3) != 0) a = 7'h78 + 7'($urandom_range(0, 7));
            else                           a = 7'($urandom);
            strobe(a);
         end else if (r <= 6) begin
            cyc({3'b000, ($urandom_range(0, 4) == 0), 4'($urandom)});
         end else if (r <= 8) begin
            idle(int'($urandom_range(1, 6)));
         end else begin
            cyc(8'($urandom));
         end
      end

      idle(2);
      repeat (3) @(negedge clk);
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, want 0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
